// File: rtl/decoder_sel_sequencer.sv
// decoder_sel_sequencer: scan sequencer that produces the 3-to-8 decoder select.
// It walks the enabled channels in ascending order and holds each one for
// dwell+1 cycles. It can run a single pass or scan continuously.
// Optional build macro: SEL_ONEHOT_EN adds a registered one-hot copy of sel.
module decoder_sel_sequencer #(
   parameter  int SEL_W   = 3,
   parameter  int DWELL_W = 8,
   localparam int N       = 1 << SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [N-1:0]       enable_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               step_pulse,
   output logic               busy,
`ifdef SEL_ONEHOT_EN
   output logic [N-1:0]       sel_onehot,
`endif
   output logic               done
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state, state_d;
   logic [DWELL_W-1:0] cnt, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [SEL_W-1:0]   sel_d;
   logic               valid_d, step_d, busy_d, done_d;

   // {found, index} of the lowest set bit of m
   function automatic logic [SEL_W:0] lowest_set(input logic [N-1:0] m);
      logic [SEL_W:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--)
         if (m[i]) r = {1'b1, SEL_W'(i)};
      return r;
   endfunction

   // Channels enabled and strictly above the current select
   logic [N-1:0] above_mask;
   for (genvar g = 0; g < N; g++) begin : g_above
      assign above_mask[g] = enable_mask[g] && (SEL_W'(g) > sel);
   end

   logic [SEL_W:0] first_hit, above_hit;
   assign first_hit = lowest_set(enable_mask);
   assign above_hit = lowest_set(above_mask);

   // Next-state and next-output decision; every output is registered below
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      dwell_d = dwell_q;
      sel_d   = sel;
      valid_d = sel_valid;
      busy_d  = busy;
      step_d  = 1'b0;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            // stop beats start, and suppresses the empty-mask done as well
            if (start && !stop) begin
               if (first_hit[SEL_W]) begin
                  state_d = SCAN;
                  sel_d   = first_hit[SEL_W-1:0];
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  step_d  = 1'b1;
                  cnt_d   = '0;
                  dwell_d = dwell;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         SCAN: begin
            if (stop) begin
               state_d = IDLE;
               sel_d   = '0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt == dwell_q) begin
               // The mask is only looked at here, so clearing the current
               // channel mid-dwell never cuts its hold short.
               if (above_hit[SEL_W] || (mode_cont && first_hit[SEL_W])) begin
                  sel_d   = above_hit[SEL_W] ? above_hit[SEL_W-1:0]
                                             : first_hit[SEL_W-1:0];
                  step_d  = 1'b1;
                  cnt_d   = '0;
                  dwell_d = dwell;
               end else begin
                  state_d = IDLE;
                  sel_d   = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end
            end else begin
               // cnt stops at dwell_q, so it cannot wrap
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Registered outputs, dwell counter and latched dwell
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         dwell_q    <= '0;
         sel        <= '0;
         sel_valid  <= 1'b0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         cnt        <= cnt_d;
         dwell_q    <= dwell_d;
         sel        <= sel_d;
         sel_valid  <= valid_d;
         step_pulse <= step_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

`ifdef SEL_ONEHOT_EN
   // One-hot select, updated on the same edge as sel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sel_onehot <= '0;
      else     sel_onehot <= valid_d ? (N'(1) << sel_d) : '0;
   end
`endif

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// tb_decoder_sel_sequencer: directed bench with a channel-level reference
// model compared every cycle, plus literal expected sequences.
module tb_decoder_sel_sequencer;
   localparam int N = 8;

   logic       clk = 1'b0, rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
   logic [7:0] mask = '0, dwell = '0;
   logic [2:0] sel;
   logic       sel_valid, step_pulse, busy, done;
`ifdef SEL_ONEHOT_EN
   logic [7:0] sel_onehot;
`endif

   decoder_sel_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
      .enable_mask(mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
      .step_pulse(step_pulse), .busy(busy),
`ifdef SEL_ONEHOT_EN
      .sel_onehot(sel_onehot),
`endif
      .done(done));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: current channel plus cycles left on it
   bit         m_scan = 0;
   int         m_ch = 0, m_left = 0;
   logic [2:0] e_sel = '0;
   bit         e_valid = 0, e_step = 0, e_busy = 0, e_done = 0;

   function automatic int first_from(input logic [7:0] m, input int from);
      for (int i = from; i < N; i++) if (m[i]) return i;
      return -1;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      e_step = 0;
      e_done = 0;
      if (rst) begin
         m_scan = 0; m_ch = 0; m_left = 0;
      end else if (!m_scan) begin
         if (start && !stop) begin
            if (mask != 0) begin
               m_scan = 1; m_ch = first_from(mask, 0); m_left = dwell; e_step = 1;
            end else e_done = 1;
         end
      end else if (stop) begin
         m_scan = 0;
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         int nxt;
         nxt = first_from(mask, m_ch + 1);
         if (nxt < 0 && mode_cont) nxt = first_from(mask, 0);
         if (nxt >= 0) begin
            m_ch = nxt; m_left = dwell; e_step = 1;
         end else begin
            m_scan = 0; e_done = 1;
         end
      end
      e_sel   = m_scan ? 3'(m_ch) : 3'd0;
      e_valid = m_scan;
      e_busy  = m_scan;
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      chk("sel", 32'(sel), 32'(e_sel));
      chk("sel_valid", 32'(sel_valid), 32'(e_valid));
      chk("step_pulse", 32'(step_pulse), 32'(e_step));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
`ifdef SEL_ONEHOT_EN
      chk("sel_onehot", 32'(sel_onehot), e_valid ? (32'd1 << e_sel) : 32'd0);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_step_on(input logic [2:0] ch, input string name);
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (sel_valid && step_pulse && sel == ch) hit = 1;
      end
      chk(name, 32'(hit), 32'd1);
   endtask

   initial begin
      int sp_sel[13]  = '{0,0,0,2,2,2,5,5,5,7,7,7,0};
      int sp_step[13] = '{1,0,0,1,0,0,1,0,0,1,0,0,0};
      int lm_sel[9]   = '{3,3,3,3,6,6,6,6,0};
      int ct_sel[4]   = '{1,7,1,7};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", {sel, sel_valid, step_pulse, busy, done}, 32'd0);
      rst = 1'b0;

      // Single pass over 1010_0101 with dwell=2
      @(negedge clk);
      mask = 8'b1010_0101; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("single_sel", 32'(sel), 32'(sp_sel[i]));
         chk("single_step", 32'(step_pulse), 32'(sp_step[i]));
         chk("single_valid", 32'(sel_valid), (i < 12) ? 32'd1 : 32'd0);
         chk("single_done", 32'(done), (i == 12) ? 32'd1 : 32'd0);
      end

      // Continuous wrap with dwell=0, then single-channel mask
      @(negedge clk);
      mask = 8'b1000_0010; dwell = 8'd0; mode_cont = 1'b1; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("cont_sel", 32'(sel), 32'(ct_sel[i]));
         chk("cont_step", 32'(step_pulse), 32'd1);
      end
      mask = 8'b0001_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("single_ch_sel", 32'(sel), 32'd4);
         chk("single_ch_step", 32'(step_pulse), 32'd1);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("cont_stopped", {sel_valid, busy, done}, 32'd0);

      // Empty mask start, then start+stop collision
      mask = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("empty_done_drop", 32'(done), 32'd0);
      mask = 8'hFF; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("collide_idle", {sel_valid, busy, done, step_pulse}, 32'd0);

      // Stop on channel 2's terminal cycle
      mask = 8'hFF; dwell = 8'd3; mode_cont = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_step_on(3'd2, "wait_ch2");
      repeat (3) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_tc", {29'd0, sel, sel_valid, busy, step_pulse, done}, 32'd0);

      // Live mask change on channel 3
      @(negedge clk);
      mask = 8'hFF; dwell = 8'd3; mode_cont = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_step_on(3'd3, "wait_ch3");
      mask = 8'b0100_0001;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         chk("live_sel", 32'(sel), 32'(lm_sel[i]));
         chk("live_done", 32'(done), (i == 8) ? 32'd1 : 32'd0);
`ifdef SEL_ONEHOT_EN
         chk("live_onehot", 32'(sel_onehot),
             (i < 4) ? 32'h08 : (i < 8) ? 32'h40 : 32'h00);
`endif
      end

      // Reset asserted mid-scan
      @(negedge clk);
      mask = 8'hFF; dwell = 8'd5; mode_cont = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_midscan", {sel, sel_valid, step_pulse, busy, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {busy, sel_valid, done}, 32'd0);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/decoder_sel_sequencer.md
Name: decoder_sel_sequencer

Overview:
- Upstream scan sequencer that generates the 3-bit select driven into the 3-to-8 decoder stage.
- Steps through the enabled channels in ascending order and holds each one for a programmable dwell time.
- Runs as a single pass or continuously, and flags each step, completion and busy state to the controller.

Parameters:
SEL_W, 3, select width; channel count N = 2**SEL_W
DWELL_W, 8, dwell counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a scan; sampled only in IDLE
stop  input  1  abort request; sampled in every state
mode_cont  input  1  1 = wrap and scan continuously, 0 = single pass; sampled at each wrap decision
enable_mask  input  N  per-channel enable, bit i enables channel i; sampled at each step decision
dwell  input  DWELL_W  hold time; each channel is held for dwell+1 cycles; sampled on entry to each channel
sel  output  SEL_W  registered channel select to the decoder
sel_valid  output  1  registered; sel is meaningful
step_pulse  output  1  registered one-cycle pulse on every channel change, including the first channel after start
busy  output  1  registered; high while in SCAN
done  output  1  registered one-cycle pulse when a single pass completes or start arrives with an empty mask

Behaviour:
- Reset (async, rst=1): state=IDLE; sel=0, sel_valid=0, step_pulse=0, busy=0, done=0; dwell counter cleared. Release takes effect on the next clk edge.
- States: IDLE and SCAN. All outputs are registered.
- IDLE:
  - start=1, stop=0, mask!=0: next cycle enter SCAN with sel = lowest set bit of mask, sel_valid=1, busy=1, step_pulse=1. Counter loads 0 and the dwell value is latched. Latency from start to sel_valid is 1 cycle.
  - start=1, mask==0: stay IDLE; done=1 for one cycle.
  - start and stop in the same cycle: stop wins; stay IDLE with no done.
- SCAN:
  - Counter increments every cycle. Terminal count is reached when counter == latched dwell, so dwell=0 gives a 1-cycle hold.
  - At terminal count, search the live enable_mask for the lowest set bit strictly above sel:
    - found: sel <= that index; step_pulse=1; counter=0; relatch dwell.
    - not found and mode_cont=1 and mask!=0: wrap to the lowest set bit; same actions as found. A single-channel mask re-selects the same index with step_pulse=1.
    - not found and mode_cont=0, or mask==0: go to IDLE next cycle; sel=0, sel_valid=0, busy=0; done=1 for one cycle.
  - Clearing the enable bit of the current channel mid-dwell does not shorten its dwell.
  - stop=1 overrides everything, including a simultaneous terminal count. Next cycle: IDLE, sel=0, sel_valid=0, busy=0, no done, no step_pulse.
  - start in SCAN is ignored.
- Search: a single-cycle combinational priority search over N bits, with no idle cycles between channels.
- Counter is DWELL_W bits and never wraps, because the compare stops it at the latched dwell.
- Reset asserted mid-scan immediately forces all outputs to their reset values. No done pulse is produced.

Optional Feature:
- Macro: SEL_ONEHOT_EN.
- Defined: adds output port sel_onehot (N bits, registered). sel_onehot = 1<<sel when the registered sel_valid is 1, otherwise 0. It updates in the same cycle as sel, and resets to 0.
- Not defined: the port and its logic are absent. The decoder stage produces the one-hot select instead. All other behaviour is identical.

Test Plan:
- Reset mid-scan: mask=8'hFF, dwell=5, mode_cont=1, start, then assert rst at cycle 4 -> all outputs 0 in the same cycle, IDLE after release, no done pulse.
- Single pass: mask=8'b1010_0101, dwell=2, mode_cont=0, pulse start -> sel=0,2,5,7, each held 3 cycles with step_pulse at each change; done pulses 1 cycle after channel 7's 3rd cycle; sel_valid falls on the same cycle as done.
- Continuous wrap and single channel: mask=8'b1000_0010, dwell=0 -> sel alternates 1,7,1,7 every cycle. Then mask=8'b0001_0000 -> sel stays 4 with step_pulse high every cycle.
- Empty mask and start/stop collision: start with mask=0 -> done pulse, busy stays 0. start+stop together with mask=8'hFF -> nothing happens.
- Stop at terminal count: mask=8'hFF, dwell=3, assert stop on channel 2's 4th cycle -> next cycle sel=0, sel_valid=0, busy=0, no step_pulse, no done.
- Live mask change: mask=8'hFF, dwell=3, on sel=3 cycle 1 change mask to 8'b0100_0001 -> channel 3 completes 4 cycles, then sel=6, then done (mode_cont=0). With SEL_ONEHOT_EN defined, sel_onehot=8'h08 then 8'h40, then 0.
